// File: rtl/pir_pkg.sv
// rtl/pir_pkg.sv - shared constants for the three-channel PIR motion monitor
package pir_pkg;
  localparam int SENSOR_W            = 7;
  localparam int DISP_W              = 8;
  localparam int ACC_W               = 10;
  localparam int N_SENSORS           = 3;
  localparam int DEFAULT_THRESHOLD   = 50;
  localparam int DEFAULT_WINDOW_LOG2 = 3;

  localparam logic [3:0] IDX_S1 = 4'd1;
  localparam logic [3:0] IDX_S2 = 4'd2;
  localparam logic [3:0] IDX_S3 = 4'd3;
endpackage

// File: rtl/pir_motion_monitor_if.sv
// rtl/pir_motion_monitor_if.sv - sensor inputs and display/alarm outputs of the monitor
interface pir_motion_monitor_if;
  logic       turn;
  logic       stop_alarm;
  logic [6:0] pir_sensor_1;
  logic [6:0] pir_sensor_2;
  logic [6:0] pir_sensor_3;
  logic [2:0] LED;
  logic       buzzer;
  logic [7:0] display_threshold;
  logic [3:0] display_from_threshold;
  logic [7:0] display_last_measurment;
  logic [3:0] display_from_measurment;
  logic [7:0] display_total_sensors;
  logic [7:0] display_average_1;
  logic [7:0] display_average_2;
  logic [7:0] display_average_3;
  logic [7:0] check_counter;
  logic [7:0] check_counter_total;

  modport slave (
    input  turn, stop_alarm, pir_sensor_1, pir_sensor_2, pir_sensor_3,
    output LED, buzzer, display_threshold, display_from_threshold,
           display_last_measurment, display_from_measurment, display_total_sensors,
           display_average_1, display_average_2, display_average_3,
           check_counter, check_counter_total
  );

  modport master (
    output turn, stop_alarm, pir_sensor_1, pir_sensor_2, pir_sensor_3,
    input  LED, buzzer, display_threshold, display_from_threshold,
           display_last_measurment, display_from_measurment, display_total_sensors,
           display_average_1, display_average_2, display_average_3,
           check_counter, check_counter_total
  );
endinterface

// File: rtl/pir_channel.sv
// rtl/pir_channel.sv - one sensor: threshold comparator, window accumulator, average register
module pir_channel
  import pir_pkg::*;
#(
  parameter int THRESHOLD   = DEFAULT_THRESHOLD,
  parameter int WINDOW_LOG2 = DEFAULT_WINDOW_LOG2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_i,
  input  logic                wrap_i,
  input  logic [SENSOR_W-1:0] reading_i,
  output logic                over_o,
  output logic [DISP_W-1:0]   avg_o
);
  localparam logic [SENSOR_W-1:0] THR = SENSOR_W'(THRESHOLD);

  logic [ACC_W-1:0]  acc_q, acc_d, sum;
  logic [DISP_W-1:0] avg_q, avg_d;

  assign over_o = (reading_i > THR);
  assign sum    = acc_q + ACC_W'(reading_i);
  assign avg_o  = avg_q;

  always_comb begin
    acc_d = acc_q;
    avg_d = avg_q;
    if (sample_i) begin
      // The closing sample is folded into the average directly, so the accumulator restarts at 0
      if (wrap_i) begin
        acc_d = '0;
        avg_d = DISP_W'(sum >> WINDOW_LOG2);
      end else begin
        acc_d = sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      avg_q <= '0;
    end else begin
      acc_q <= acc_d;
      avg_q <= avg_d;
    end
  end
endmodule

// File: rtl/pir_motion_monitor.sv
// rtl/pir_motion_monitor.sv - three-channel PIR monitor: window counter, alarm latch, max tracking
module pir_motion_monitor
  import pir_pkg::*;
#(
  parameter int THRESHOLD   = DEFAULT_THRESHOLD,
  parameter int WINDOW_LOG2 = DEFAULT_WINDOW_LOG2
) (
  input logic                    clk,
  input logic                    rst,
  pir_motion_monitor_if.slave    bus
);
  logic [SENSOR_W-1:0]  reading [N_SENSORS];
  logic [N_SENSORS-1:0] over;
  logic [DISP_W-1:0]    avg [N_SENSORS];
  logic                 sample, wrap;

  logic [N_SENSORS-1:0]   led_q, led_d;
  logic                   alarm_q, alarm_d;
  logic [DISP_W-1:0]      total_q, total_d;
  logic [SENSOR_W-1:0]    max_q, max_d;
  logic [3:0]             idx_q, idx_d;
  logic [WINDOW_LOG2-1:0] cnt_q, cnt_d;
  logic [DISP_W-1:0]      win_q, win_d;

  assign reading[0] = bus.pir_sensor_1;
  assign reading[1] = bus.pir_sensor_2;
  assign reading[2] = bus.pir_sensor_3;
  assign sample     = bus.turn;
  assign wrap       = sample && (cnt_q == '1);

  for (genvar g = 0; g < N_SENSORS; g++) begin : g_ch
    pir_channel #(.THRESHOLD(THRESHOLD), .WINDOW_LOG2(WINDOW_LOG2)) u_ch (
      .clk       (clk),
      .rst       (rst),
      .sample_i  (sample),
      .wrap_i    (wrap),
      .reading_i (reading[g]),
      .over_o    (over[g]),
      .avg_o     (avg[g])
    );
  end

  always_comb begin
    led_d   = sample ? over : '0;
    alarm_d = alarm_q;
    total_d = total_q;
    max_d   = max_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    if (sample && (|over)) alarm_d = 1'b1;
    // A stop request beats a same-cycle set; a persisting reading re-arms on the following sample
    if (bus.stop_alarm)   alarm_d = 1'b0;
    if (!alarm_q && alarm_d && (total_q != '1)) total_d = total_q + 1'b1;
    if (sample) begin
      max_d = reading[0];
      idx_d = IDX_S1;
      if (reading[1] > max_d) begin
        max_d = reading[1];
        idx_d = IDX_S2;
      end
      if (reading[2] > max_d) begin
        max_d = reading[2];
        idx_d = IDX_S3;
      end
      cnt_d = cnt_q + 1'b1;
      if (wrap) win_d = win_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q   <= '0;
      alarm_q <= 1'b0;
      total_q <= '0;
      max_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      win_q   <= '0;
    end else begin
      led_q   <= led_d;
      alarm_q <= alarm_d;
      total_q <= total_d;
      max_q   <= max_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
    end
  end

  assign bus.LED                     = led_q;
  assign bus.buzzer                  = alarm_q;
  assign bus.display_threshold       = DISP_W'(THRESHOLD);
  assign bus.display_from_threshold  = {|led_q, led_q};
  assign bus.display_last_measurment = DISP_W'(max_q);
  assign bus.display_from_measurment = idx_q;
  assign bus.display_total_sensors   = total_q;
  assign bus.display_average_1       = avg[0];
  assign bus.display_average_2       = avg[1];
  assign bus.display_average_3       = avg[2];
  assign bus.check_counter           = DISP_W'(cnt_q);
  assign bus.check_counter_total     = win_q;
endmodule

// File: tb/tb_pir_motion_monitor.sv
// tb/tb_pir_motion_monitor.sv - scoreboard bench for pir_motion_monitor with a window-list model
module tb_pir_motion_monitor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pir_motion_monitor_if bus();

  pir_motion_monitor dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int cyc;
    int led, dft, buz, tot, lastm, fromm, avg1, avg2, avg3, cc, cct;
  } exp_t;

  exp_t sb[$];
  int   cyc_cnt = 0;
  int   vectors = 0;
  int   miscompares = 0;

  bit m_alarm;
  int m_tot, m_led, m_max, m_idx, m_nwin;
  int m_avg[3];
  int win1[$], win2[$], win3[$];

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc_cnt, act, expv);
    end
  endtask

  function automatic int qsum(input int q[$]);
    int s = 0;
    foreach (q[i]) s += q[i];
    return s;
  endfunction

  task automatic apply(input bit r, input bit t, input bit st, input int a, input int b, input int c);
    int   s[3];
    int   over_bits;
    bit   prev;
    exp_t e;
    @(posedge clk);
    #1;
    rst = r;
    bus.turn = t;
    bus.stop_alarm = st;
    bus.pir_sensor_1 = 7'(a);
    bus.pir_sensor_2 = 7'(b);
    bus.pir_sensor_3 = 7'(c);
    s[0] = a; s[1] = b; s[2] = c;
    if (r) begin
      m_alarm = 0; m_tot = 0; m_led = 0; m_max = 0; m_idx = 0; m_nwin = 0;
      m_avg[0] = 0; m_avg[1] = 0; m_avg[2] = 0;
      win1.delete(); win2.delete(); win3.delete();
    end else begin
      over_bits = 0;
      for (int i = 0; i < 3; i++) if (s[i] > 50) over_bits |= (1 << i);
      m_led = t ? over_bits : 0;
      prev = m_alarm;
      if (t && over_bits != 0) m_alarm = 1;
      if (st) m_alarm = 0;
      if (!prev && m_alarm && m_tot < 255) m_tot++;
      if (t) begin
        m_max = -1;
        for (int i = 0; i < 3; i++) if (s[i] > m_max) begin m_max = s[i]; m_idx = i + 1; end
        win1.push_back(a); win2.push_back(b); win3.push_back(c);
        if (win1.size() == 8) begin
          m_avg[0] = qsum(win1) / 8;
          m_avg[1] = qsum(win2) / 8;
          m_avg[2] = qsum(win3) / 8;
          win1.delete(); win2.delete(); win3.delete();
          m_nwin = (m_nwin + 1) % 256;
        end
      end
    end
    e.cyc = cyc_cnt + 1;
    e.led = m_led;
    e.dft = (m_led != 0 ? 8 : 0) + m_led;
    e.buz = m_alarm;
    e.tot = m_tot;
    e.lastm = m_max;
    e.fromm = m_idx;
    e.avg1 = m_avg[0]; e.avg2 = m_avg[1]; e.avg3 = m_avg[2];
    e.cc = win1.size();
    e.cct = m_nwin;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0 && sb[0].cyc == cyc_cnt) begin
      e = sb.pop_front();
      chk("LED", int'(bus.LED), e.led);
      chk("display_from_threshold", int'(bus.display_from_threshold), e.dft);
      chk("buzzer", int'(bus.buzzer), e.buz);
      chk("display_total_sensors", int'(bus.display_total_sensors), e.tot);
      chk("display_last_measurment", int'(bus.display_last_measurment), e.lastm);
      chk("display_from_measurment", int'(bus.display_from_measurment), e.fromm);
      chk("display_average_1", int'(bus.display_average_1), e.avg1);
      chk("display_average_2", int'(bus.display_average_2), e.avg2);
      chk("display_average_3", int'(bus.display_average_3), e.avg3);
      chk("check_counter", int'(bus.check_counter), e.cc);
      chk("check_counter_total", int'(bus.check_counter_total), e.cct);
      chk("display_threshold", int'(bus.display_threshold), 50);
    end
  end

  function automatic int rand_reading();
    case ($urandom_range(0, 4))
      0: return 49 + int'($urandom_range(0, 2));
      1: return 0;
      default: return int'($urandom_range(0, 127));
    endcase
  endfunction

  initial begin
    int v;
    bus.turn = 0; bus.stop_alarm = 0;
    bus.pir_sensor_1 = 0; bus.pir_sensor_2 = 0; bus.pir_sensor_3 = 0;

    apply(1, 0, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) apply(0, 1, 0, 10, 10, 10);
    apply(0, 1, 0, 20, 51, 20);
    apply(0, 1, 1, 20, 20, 20);
    apply(0, 1, 0, 50, 20, 20);
    apply(0, 1, 0, 20, 20, 100);
    apply(0, 1, 1, 20, 20, 100);
    apply(0, 1, 0, 20, 20, 100);
    apply(0, 0, 0, 20, 20, 100);
    apply(0, 0, 1, 20, 20, 100);

    apply(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) for (int k = 0; k < 3; k++) apply(0, 0, 0, 99, 99, 99);
      apply(0, 1, 0, i * 8, 0, 0);
    end

    apply(0, 1, 0, 90, 90, 90);
    apply(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) apply(0, 1, 0, 5, 70, 70);
    apply(1, 1, 0, 90, 90, 90);
    apply(0, 1, 0, 0, 0, 0);

    for (int i = 0; i < 260; i++) begin
      apply(0, 1, 0, 127, 0, 0);
      apply(0, 0, 1, 0, 0, 0);
    end

    for (int i = 0; i < 400; i++) begin
      v = rand_reading();
      if ($urandom_range(0, 5) == 0)
        apply($urandom_range(0, 39) == 0, $urandom_range(0, 4) != 0, $urandom_range(0, 9) == 0, v, v, v);
      else
        apply($urandom_range(0, 39) == 0, $urandom_range(0, 4) != 0, $urandom_range(0, 9) == 0,
              rand_reading(), rand_reading(), rand_reading());
    end

    for (int i = 0; i < 3; i++) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
